// File: rtl/icache_dm_if.sv
// Bundled CPU fetch, backing-memory and statistics signals of the direct-mapped
// instruction cache. The cache connects through the slave modport, and whoever
// drives it (CPU plus memory) connects through master.
interface icache_dm_if;
    logic         in_cpu_read_en;
    logic [31:0]  in_cpu_addr;
    logic         in_flush;
    logic [31:0]  out_cpu_data;
    logic         out_cpu_ready;
    logic         out_mem_read_en;
    logic [31:0]  out_mem_addr;
    logic [127:0] in_mem_read_data;
    logic         in_mem_ready;
    logic [31:0]  out_hit_count;
    logic [31:0]  out_miss_count;

    modport master (
        output in_cpu_read_en, in_cpu_addr, in_flush, in_mem_read_data, in_mem_ready,
        input  out_cpu_data, out_cpu_ready, out_mem_read_en, out_mem_addr,
               out_hit_count, out_miss_count
    );

    modport slave (
        input  in_cpu_read_en, in_cpu_addr, in_flush, in_mem_read_data, in_mem_ready,
        output out_cpu_data, out_cpu_ready, out_mem_read_en, out_mem_addr,
               out_hit_count, out_miss_count
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with 16-byte lines. A hit answers in one cycle.
// A miss refills the whole line from memory and forwards the requested word
// straight from the returned data. A flush that arrives while a refill is
// outstanding is deferred until the response has been delivered.
module icache_dm #(
    parameter int NUM_LINES = 4
) (
    input logic       clk,
    input logic       reset,
    icache_dm_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

    state_t state;
    state_t next_state;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [127:0]         lines [NUM_LINES];

    logic [31:2] req_addr;
    logic        flush_pending;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] refill_idx;
    logic [TAG_W-1:0] refill_tag;
    logic             hit;
    logic             miss;
    logic             refill;
    logic             unused_addr_bits;

    assign cpu_idx    = bus.in_cpu_addr[IDX_W+3:4];
    assign cpu_tag    = bus.in_cpu_addr[31:IDX_W+4];
    assign refill_idx = req_addr[IDX_W+3:4];
    assign refill_tag = req_addr[31:IDX_W+4];

    assign unused_addr_bits = ^bus.in_cpu_addr[1:0];

    // A flush in the same cycle as a request forces a miss, because the flush wipes the line at that edge.
    assign hit    = (state == IDLE) && bus.in_cpu_read_en && !bus.in_flush &&
                    valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
    assign miss   = (state == IDLE) && bus.in_cpu_read_en && !hit;
    assign refill = (state == MISS) && bus.in_mem_ready;

    assign bus.out_mem_read_en = (state == MISS) && !bus.in_mem_ready;
    assign bus.out_mem_addr    = {req_addr[31:4], 4'b0000};
    assign bus.out_cpu_data    = cpu_data;
    assign bus.out_cpu_ready   = cpu_ready;
    assign bus.out_hit_count   = hit_count;
    assign bus.out_miss_count  = miss_count;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE branches on hit/miss, MISS waits for memory, RESP always returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hit) begin
                    next_state = RESP;
                end else if (miss) begin
                    next_state = MISS;
                end
            end
            MISS: begin
                if (bus.in_mem_ready) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control registers: response word, ready pulse, counters, valid bits and the deferred flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid         <= '0;
            flush_pending <= 1'b0;
            cpu_ready     <= 1'b0;
            cpu_data      <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            req_addr      <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_flush) begin
                        valid <= '0;
                    end
                    if (hit) begin
                        cpu_data  <= lines[cpu_idx][{bus.in_cpu_addr[3:2], 5'b00000} +: 32];
                        cpu_ready <= 1'b1;
                        hit_count <= hit_count + 32'd1;
                    end else if (miss) begin
                        req_addr   <= bus.in_cpu_addr[31:2];
                        miss_count <= miss_count + 32'd1;
                    end
                end
                MISS: begin
                    if (bus.in_flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (bus.in_mem_ready) begin
                        valid[refill_idx] <= 1'b1;
                        cpu_data          <= bus.in_mem_read_data[{req_addr[3:2], 5'b00000} +: 32];
                        cpu_ready         <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.in_flush || flush_pending) begin
                        valid         <= '0;
                        flush_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays are written only on a refill and are left unreset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (refill && !reset) begin
            lines[refill_idx] <= bus.in_mem_read_data;
            tags[refill_idx]  <= refill_tag;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hit, conflict misses, flushes in IDLE
// and during a refill, a held request, and reset in the middle of a refill.
module tb_icache_dm;
    logic clk = 1'b0;
    logic reset;

    icache_dm_if bus ();

    icache_dm #(.NUM_LINES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic read_en, input logic [31:0] addr, input logic flush);
        bus.in_cpu_read_en = read_en;
        bus.in_cpu_addr    = addr;
        bus.in_flush       = flush;
    endtask

    function automatic logic [127:0] line_for(input logic [31:0] addr);
        logic [31:0]  base;
        logic [127:0] line;
        base = {addr[31:4], 4'b0000};
        if (base == 32'h40) begin
            line = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
        end else begin
            for (int n = 0; n < 4; n++) begin
                line[n*32 +: 32] = 32'hA500_0000 ^ (base << 4) ^ 32'(n);
            end
        end
        return line;
    endfunction

    function automatic logic [31:0] word_for(input logic [31:0] addr);
        logic [127:0] line;
        line = line_for(addr);
        return line[int'(addr[3:2])*32 +: 32];
    endfunction

    task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_miss,
                         input int lat, input bit flush_first, input int flush_at);
        logic [31:0] exp_data;
        exp_data = word_for(addr);
        applyStimulus(1'b1, addr, flush_first);
        tick();
        bus.in_flush = 1'b0;
        if (exp_miss) begin
            exp_misses++;
            checkOutput({tag, "_ready_in_miss"}, 32'(bus.out_cpu_ready), 32'd0);
            // A held request with a wandering address must not disturb the refill.
            applyStimulus(1'b1, 32'hDEAD_BEE0, 1'b0);
            for (int i = 0; i < lat; i++) begin
                checkOutput({tag, "_mem_rd"}, 32'(bus.out_mem_read_en), 32'd1);
                checkOutput({tag, "_mem_addr"}, bus.out_mem_addr, {addr[31:4], 4'b0000});
                if (i == flush_at) begin
                    bus.in_flush = 1'b1;
                end
                tick();
                bus.in_flush = 1'b0;
            end
            bus.in_cpu_read_en   = 1'b0;
            bus.in_mem_read_data = line_for(addr);
            bus.in_mem_ready     = 1'b1;
            #1;
            checkOutput({tag, "_mem_rd_drop"}, 32'(bus.out_mem_read_en), 32'd0);
            tick();
            bus.in_mem_ready     = 1'b0;
            bus.in_mem_read_data = '0;
            checkOutput({tag, "_ready"}, 32'(bus.out_cpu_ready), 32'd1);
            checkOutput({tag, "_data"}, bus.out_cpu_data, exp_data);
        end else begin
            exp_hits++;
            bus.in_cpu_read_en = 1'b0;
            checkOutput({tag, "_ready"}, 32'(bus.out_cpu_ready), 32'd1);
            checkOutput({tag, "_data"}, bus.out_cpu_data, exp_data);
            checkOutput({tag, "_no_mem_rd"}, 32'(bus.out_mem_read_en), 32'd0);
        end
        tick();
        checkOutput({tag, "_ready_drop"}, 32'(bus.out_cpu_ready), 32'd0);
        checkOutput({tag, "_data_hold"}, bus.out_cpu_data, exp_data);
    endtask

    task automatic check_counters(input string tag);
        checkOutput({tag, "_hits"}, bus.out_hit_count, 32'(exp_hits));
        checkOutput({tag, "_misses"}, bus.out_miss_count, 32'(exp_misses));
    endtask

    // Main directed sequence.
    initial begin
        applyStimulus(1'b0, 32'h0, 1'b0);
        bus.in_mem_ready     = 1'b0;
        bus.in_mem_read_data = '0;
        reset = 1'b1;
        tick();
        tick();
        checkOutput("reset_ready", 32'(bus.out_cpu_ready), 32'd0);
        checkOutput("reset_data", bus.out_cpu_data, 32'd0);
        checkOutput("reset_mem_rd", 32'(bus.out_mem_read_en), 32'd0);
        check_counters("reset");
        reset = 1'b0;

        fetch("cold", 32'h48, 1'b1, 10, 1'b0, -1);
        checkOutput("cold_word", bus.out_cpu_data, 32'h33330003);
        check_counters("cold");

        fetch("hit", 32'h4C, 1'b0, 0, 1'b0, -1);
        checkOutput("hit_word", bus.out_cpu_data, 32'h44440004);
        check_counters("hit");

        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);

        fetch("conf_a", 32'h40, 1'b1, 2, 1'b0, -1);
        fetch("conf_b", 32'h80, 1'b1, 2, 1'b0, -1);
        fetch("conf_c", 32'h40, 1'b1, 2, 1'b0, -1);
        check_counters("conflict");

        fetch("flush_req", 32'h44, 1'b1, 1, 1'b1, -1);
        fetch("idx1_miss", 32'h54, 1'b1, 3, 1'b0, -1);
        fetch("idx1_hit", 32'h58, 1'b0, 0, 1'b0, -1);
        fetch("evict", 32'h80, 1'b1, 2, 1'b0, -1);
        fetch("flush_miss", 32'h40, 1'b1, 4, 1'b0, 2);
        fetch("after_flush", 32'h40, 1'b1, 2, 1'b0, -1);
        fetch("idx1_gone", 32'h58, 1'b1, 2, 1'b0, -1);
        check_counters("flush");

        applyStimulus(1'b1, 32'h44, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checkOutput($sformatf("held_ready_c%0d", c), 32'(bus.out_cpu_ready),
                        (c == 1 || c == 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        exp_hits += 2;
        checkOutput("held_data", bus.out_cpu_data, 32'h22220002);
        check_counters("held");

        applyStimulus(1'b1, 32'hC0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("rst_miss_mem_rd", 32'(bus.out_mem_read_en), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        checkOutput("rst_miss_mem_rd_drop", 32'(bus.out_mem_read_en), 32'd0);
        checkOutput("rst_miss_ready", 32'(bus.out_cpu_ready), 32'd0);
        bus.in_mem_read_data = line_for(32'hC0);
        bus.in_mem_ready     = 1'b1;
        tick();
        bus.in_mem_ready     = 1'b0;
        checkOutput("stale_ready", 32'(bus.out_cpu_ready), 32'd0);
        checkOutput("stale_data", bus.out_cpu_data, 32'd0);
        tick();
        checkOutput("stale_ready_late", 32'(bus.out_cpu_ready), 32'd0);
        check_counters("rst_miss");

        fetch("post_reset", 32'h40, 1'b1, 2, 1'b0, -1);
        check_counters("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 4, meaning the number of direct-mapped lines; it must be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_cpu_read_en, input, 1 bit: fetch request, held by the CPU until out_cpu_ready.
REQ-005 The block SHALL have port in_cpu_addr, input, 32 bits: byte address of the fetch; bits [1:0] are ignored.
REQ-006 The block SHALL have port in_flush, input, 1 bit: a one-cycle pulse that invalidates all lines.
REQ-007 The block SHALL have port out_cpu_data, output, 32 bits: the fetched instruction word, valid while out_cpu_ready=1.
REQ-008 The block SHALL have port out_cpu_ready, output, 1 bit: a one-cycle response pulse.
REQ-009 The block SHALL have port out_mem_read_en, output, 1 bit: line read request to the backing memory.
REQ-010 The block SHALL have port out_mem_addr, output, 32 bits: line-aligned byte address, with bits [3:0]=0.
REQ-011 The block SHALL have port in_mem_read_data, input, 128 bits: the returned line; word n is bits [32n+31:32n].
REQ-012 The block SHALL have port in_mem_ready, input, 1 bit: a one-cycle pulse from memory, with data valid in the same cycle.
REQ-013 The block SHALL have port out_hit_count, output, 32 bits: the number of hits, wrapping.
REQ-014 The block SHALL have port out_miss_count, output, 32 bits: the number of misses, wrapping.

Function
REQ-015 The address SHALL decode as follows: word select [3:2]; index [3+log2(NUM_LINES):4]; tag, all bits above the index.
REQ-016 Each line SHALL store 128 bits of data, a tag and a valid bit.
REQ-017 The FSM SHALL have three states: IDLE, MISS and RESP.
REQ-018 IDLE with in_cpu_read_en=1, valid and tag-equal (hit):
- out_cpu_data is loaded from the indexed line word.
- out_cpu_ready is set to 1.
- out_hit_count is incremented.
- The FSM goes to RESP.
- Hit latency is 1 cycle.
REQ-019 IDLE with in_cpu_read_en=1, otherwise (miss):
- The request address is captured.
- out_miss_count is incremented.
- The FSM goes to MISS.
REQ-020 out_mem_read_en SHALL be combinational: (state==MISS) AND NOT in_mem_ready. This ensures the memory never relaunches a read after the ready pulse.
REQ-021 out_mem_addr SHALL equal {captured_addr[31:4],4'b0} in MISS, and SHALL hold that value from the first cycle of MISS until in_mem_ready.
REQ-022 MISS with in_mem_ready=1:
- in_mem_read_data, the tag and valid=1 are written into the indexed line.
- out_cpu_data is set to the selected word taken directly from in_mem_read_data.
- out_cpu_ready is set to 1.
- The FSM goes to RESP.
REQ-023 In RESP, out_cpu_ready SHALL return to 0 and the FSM SHALL go to IDLE; requests seen in RESP are not accepted. Maximum throughput is therefore 1 fetch per 2 cycles.
REQ-024 in_cpu_read_en SHALL be ignored in MISS; in_cpu_addr changes during MISS have no effect.
REQ-025 in_mem_ready SHALL be ignored in IDLE and RESP.
REQ-026 in_flush in IDLE or RESP SHALL clear all valid bits at that edge. In IDLE, a request sampled in the same cycle is evaluated as a miss.
REQ-027 in_flush in MISS SHALL be latched as a pending flush:
- The refill completes and its word is still returned to the CPU.
- All valid bits, including the refilled line, are cleared on the RESP->IDLE edge.
REQ-028 The counters SHALL wrap from 0xFFFFFFFF to 0; counters are never incremented in MISS or RESP.
REQ-029 out_cpu_data SHALL hold its last value when out_cpu_ready=0.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL set:
- state to IDLE;
- all valid bits and the pending flush to 0;
- out_cpu_ready to 0;
- out_cpu_data to 0;
- both counters to 0.
REQ-031 Reset SHALL NOT be required to clear tag or data arrays.
REQ-032 Reset during MISS SHALL abandon the refill. out_mem_read_en drops in the first cycle after the reset edge, and a later in_mem_ready is ignored.

Verification
REQ-033 Cold miss: memory line 0x40 = {0x44440004,0x33330003,0x22220002,0x11110001}; fetch 0x48, with memory ready 10 cycles after the read.
- out_mem_read_en=1 with out_mem_addr=0x40 until in_mem_ready.
- out_cpu_data=0x33330003 with ready the cycle after in_mem_ready.
- miss_count=1.
REQ-034 Hit: following REQ-033, fetch 0x4C.
- out_cpu_ready=1 the cycle after request, with data 0x44440004.
- No memory request is issued.
- hit_count=1.
REQ-035 Conflict: with NUM_LINES=4, fetch 0x40, then 0x80 (same index 0), then 0x40.
- The result is three misses.
- out_mem_addr takes the values 0x40, 0x80, 0x40.
REQ-036 Flush during MISS: pulse in_flush while the 0x40 refill is pending.
- Data is still returned.
- A subsequent fetch of 0x40 misses again.
REQ-037 Reset mid-MISS: assert reset 3 cycles into MISS.
- out_mem_read_en=0 in the next cycle.
- A stale in_mem_ready pulse produces no out_cpu_ready.
- Both counters=0.
REQ-038 Held request: CPU holds in_cpu_read_en=1 at 0x44 (hit) for 4 cycles.
- out_cpu_ready pulses in cycles 1 and 3 only.
- hit_count=2.
